// File: rtl/mul_3b.sv
// Registered unsigned multiplier built from an explicit shift-and-add partial-product array.
// Define MUL_PIPE_EN to register the partial products before the final add (latency 2 instead of 1).
`timescale 1ns/1ps

module mul_3b #(
    parameter int WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   p
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] pp [WIDTH];
    logic [PW-1:0] p_d;
    logic [PW-1:0] p_q;
    logic          valid_q;

    function automatic logic [PW-1:0] sum_pp(input logic [PW-1:0] v [WIDTH]);
        logic [PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            acc = acc + v[i];
        end
        return acc;
    endfunction

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp[i] = b[i] ? (PW'(a) << i) : '0;
        end
    end

`ifdef MUL_PIPE_EN
    logic [PW-1:0] pp_q [WIDTH];
    logic          pv_q;

    // Partial products captured every cycle; pv_q says whether they belong to a real pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                pp_q[i] <= '0;
            end
            pv_q <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                pp_q[i] <= pp[i];
            end
            pv_q <= in_valid;
        end
    end

    always_comb begin
        p_d = sum_pp(pp_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= pv_q;
            if (pv_q) begin
                p_q <= p_d;
            end
        end
    end
`else
    always_comb begin
        p_d = sum_pp(pp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                p_q <= p_d;
            end
        end
    end
`endif

    assign p         = p_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mul_3b.sv
// Scoreboard bench for mul_3b: expected products queued at issue, checked by a separate monitor.
`timescale 1ns/1ps

module tb_mul_3b;

`ifdef MUL_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int unsigned due;
        int unsigned val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] a = '0;
    logic [2:0] b = '0;
    logic       out_valid;
    logic [5:0] p;

    logic       in4_valid = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       out4_valid;
    logic [7:0] p4;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned last_p = 0;
    int          checks = 0;
    int          passes = 0;

    mul_3b dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .p         (p)
    );

    mul_3b #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in4_valid),
        .a         (a4),
        .b         (b4),
        .out_valid (out4_valid),
        .p         (p4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    // Drive one cycle of stimulus; valid pairs are queued with the cycle they must appear.
    task automatic drive(input logic v, input int unsigned av, input int unsigned bv);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        a = 3'(av);
        b = 3'(bv);
        if (v) begin
            e.due = cyc + LAT;
            e.val = av * bv;
            sb.push_back(e);
        end
    endtask

    // Monitor: product due this cycle must be presented, otherwise idle with p held.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    chk("out_valid", out_valid, 1);
                    chk("product", p, e.val);
                    last_p = e.val;
                end else begin
                    chk("idle_valid", out_valid, 0);
                    chk("hold_p", p, last_p);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_p", p, 0);
        chk("reset_valid", out_valid, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                drive(1, i, j);

        for (int i = 0; i < 5; i++) drive(1, 7, i + 3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_p", p, 0);
        chk("async_rst_valid", out_valid, 0);
        sb.delete();
        last_p = 0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 6, 4);
        drive(0, 0, 0);

        drive(1, 3, 4);
        drive(0, 7, 7);
        drive(0, 7, 7);
        drive(0, 5, 2);

        drive(1, 2, 3);
        drive(1, 7, 1);
        drive(1, 0, 5);
        drive(0, 0, 0);

        for (int i = 0; i < 200; i++)
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7));

        for (int i = 0; i < LAT + 2; i++) drive(0, $urandom_range(0, 7), $urandom_range(0, 7));
        chk("scoreboard_drained", sb.size(), 0);

        for (int k = 0; k < 2; k++) begin
            int unsigned av;
            int unsigned bv;
            av = (k == 0) ? 15 : 9;
            bv = (k == 0) ? 15 : 13;
            @(negedge clk);
            in4_valid = 1'b1;
            a4 = 4'(av);
            b4 = 4'(bv);
            @(negedge clk);
            in4_valid = 1'b0;
            repeat (LAT - 1) @(negedge clk);
            chk("w4_valid", out4_valid, 1);
            chk("w4_product", p4, av * bv);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
